// File: rtl/multiplicador_4bits_seq_if.sv
// rtl/multiplicador_4bits_seq_if.sv - start/operand/result bundle of the sequential multiplier
interface multiplicador_4bits_seq_if #(
  parameter int LARGURA = 4
);
  logic                   inicio;
  logic [LARGURA-1:0]     multiplicando;
  logic [LARGURA-1:0]     multiplicador;
  logic [2*LARGURA-1:0]   produto;
  logic                   ocupado;
  logic                   pronto;

  modport master (
    output inicio, multiplicando, multiplicador,
    input  produto, ocupado, pronto
  );

  modport slave (
    input  inicio, multiplicando, multiplicador,
    output produto, ocupado, pronto
  );
endinterface

// File: rtl/multiplicador_4bits_seq.sv
// rtl/multiplicador_4bits_seq.sv - unsigned shift-and-add multiplier, one multiplier bit per clock
module multiplicador_4bits_seq #(
  parameter int LARGURA = 4
) (
  input logic                      clk,
  input logic                      rst,
  multiplicador_4bits_seq_if.slave bus
);
  localparam int PW = 2 * LARGURA;
  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] CNT_ULT = CW'(LARGURA - 1);

  typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

  estado_t              estado_q;
  logic [PW-1:0]        mcand_q;
  logic [LARGURA-1:0]   mult_q;
  logic [PW-1:0]        acc_q;
  logic [PW-1:0]        acc_d;
  logic [PW-1:0]        produto_q;
  logic [CW-1:0]        cnt_q;

  // Accumulator value including the current iteration's partial product.
  assign acc_d = mult_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      produto_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (estado_q)
        OCIOSO, FIM: begin
          if (bus.inicio) begin
            mcand_q  <= {{LARGURA{1'b0}}, bus.multiplicando};
            mult_q   <= bus.multiplicador;
            acc_q    <= '0;
            cnt_q    <= '0;
            estado_q <= CALC;
          end else begin
            estado_q <= OCIOSO;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_ULT) begin
            produto_q <= acc_d;
            estado_q  <= FIM;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign bus.produto = produto_q;
  assign bus.ocupado = (estado_q == CALC);
  assign bus.pronto  = (estado_q == FIM);
endmodule
